huffman_packer: RTL and testbench

HUFFMAN_PACKER -- requirements
Module: huffman_packer

---
 rtl/huffman_pkg.sv | 23 ++
 rtl/huffman_packer_if.sv | 21 ++
 rtl/huffman_len.sv | 17 +
 rtl/huffman_packer.sv | 137 +++++++++++++
 tb/tb_huffman_packer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/huffman_pkg.sv
// Shared types and sizing for the Huffman bit packer and its length helper.
package huffman_pkg;

    localparam int NUM_SYMS = 6;
    localparam int CODE_W   = 8;
    localparam int LEN_W    = 4;
    localparam int ACC_W    = 16;
    localparam int BCNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Low-ones mask of the given length; len 8 yields 8'hFF.
    function automatic logic [CODE_W-1:0] low_mask(input logic [LEN_W-1:0] len);
        logic [CODE_W:0] m;
        m = ((CODE_W+1)'(1) << len) - (CODE_W+1)'(1);
        return m[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/huffman_packer_if.sv
// Symbol-in / byte-out streaming handshake of the Huffman packer.
interface huffman_packer_if;

    logic       sym_valid;
    logic [7:0] sym;
    logic       sym_ready;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_ready;

    modport master (
        output sym_valid, sym, byte_ready,
        input  sym_ready, byte_valid, byte_out
    );

    modport slave (
        input  sym_valid, sym, byte_ready,
        output sym_ready, byte_valid, byte_out
    );

endinterface

// File: rtl/huffman_len.sv
// Codeword length from a contiguous low-ones mask (popcount, 0..8).
module huffman_len
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0] mask,
    output logic [LEN_W-1:0]  len
);

    always_comb begin
        len = '0;
        // NOTE: blocking '=' is required here; each loop iteration must see the sum built so far.
        for (int i = 0; i < CODE_W; i++) begin
            len = len + LEN_W'(mask[i]);
        end
    end

endmodule

// File: rtl/huffman_packer.sv
// Packs variable-length Huffman codewords MSB-first into a byte stream,
// with flush-to-byte padding and a per-symbol error flag.
module huffman_packer
    import huffman_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [7:0]       HC1,
    input  logic [7:0]       HC2,
    input  logic [7:0]       HC3,
    input  logic [7:0]       HC4,
    input  logic [7:0]       HC5,
    input  logic [7:0]       HC6,
    input  logic [7:0]       M1,
    input  logic [7:0]       M2,
    input  logic [7:0]       M3,
    input  logic [7:0]       M4,
    input  logic [7:0]       M5,
    input  logic [7:0]       M6,
    input  logic             flush,
    huffman_packer_if.slave  stream,
    output logic             done,
    output logic             err,
    output logic [15:0]      sym_cnt
);

    logic [CODE_W-1:0] hc_in   [NUM_SYMS];
    logic [CODE_W-1:0] m_in    [NUM_SYMS];
    logic [LEN_W-1:0]  len_new [NUM_SYMS];

    assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
    assign m_in  = '{M1, M2, M3, M4, M5, M6};

    for (genvar g = 0; g < NUM_SYMS; g++) begin : g_len
        huffman_len u_len (
            .mask (m_in[g]),
            .len  (len_new[g])
        );
    end

    state_t            state_q, state_d;
    logic              cv_q;
    logic [CODE_W-1:0] hc_q  [NUM_SYMS];
    logic [LEN_W-1:0]  len_q [NUM_SYMS];
    logic [ACC_W-1:0]  acc_q;
    logic [BCNT_W-1:0] bcnt_q;

    logic              load;
    logic              accept;
    logic              byte_fire;
    logic [LEN_W-1:0]  sel_len;
    logic [CODE_W-1:0] sel_code;
    logic [BCNT_W-1:0] shamt;
    logic [ACC_W-1:0]  ins;

    assign load = (state_q == IDLE) && code_valid && !cv_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (load)           state_d = RUN;
            RUN:     if (flush)          state_d = FLUSH;
            FLUSH:   if (bcnt_q == '0)   state_d = RUN;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign stream.sym_ready  = (state_q == RUN) && (bcnt_q < BCNT_W'(8)) && !flush;
    assign stream.byte_valid = ((state_q != IDLE) && (bcnt_q >= BCNT_W'(8)))
                             || ((state_q == FLUSH) && (bcnt_q != '0));
    assign stream.byte_out   = acc_q[ACC_W-1:ACC_W-8];

    assign accept    = stream.sym_valid && stream.sym_ready;
    assign byte_fire = stream.byte_valid && stream.byte_ready;

    // Unknown symbols select length 0 and therefore fall into the error path.
    always_comb begin
        sel_len  = '0;
        sel_code = '0;
        for (int k = 0; k < NUM_SYMS; k++) begin
            if (stream.sym == 8'(k + 1)) begin
                sel_len  = len_q[k];
                sel_code = hc_q[k];
            end
        end
        shamt = BCNT_W'(ACC_W) - bcnt_q - BCNT_W'(sel_len);
        ins   = {8'h00, sel_code & low_mask(sel_len)} << shamt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // A code_valid level held through reset must not count as a new load edge.
            cv_q    <= 1'b1;
            acc_q   <= '0;
            bcnt_q  <= '0;
            sym_cnt <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
            // NOTE: the code tables are a handful of flops, not a RAM, so they can and do take reset.
            for (int k = 0; k < NUM_SYMS; k++) begin
                hc_q[k]  <= '0;
                len_q[k] <= '0;
            end
        end else begin
            cv_q <= code_valid;
            done <= (state_q == FLUSH) && (bcnt_q == '0);

            if (load) begin
                for (int k = 0; k < NUM_SYMS; k++) begin
                    hc_q[k]  <= hc_in[k];
                    len_q[k] <= len_new[k];
                end
            end

            if (accept) begin
                sym_cnt <= sym_cnt + 16'd1;
                if (sel_len == '0) begin
                    err <= 1'b1;
                end else begin
                    acc_q  <= acc_q | ins;
                    bcnt_q <= bcnt_q + BCNT_W'(sel_len);
                end
            end else if (byte_fire) begin
                acc_q  <= acc_q << 8;
                bcnt_q <= (bcnt_q >= BCNT_W'(8)) ? bcnt_q - BCNT_W'(8) : '0;
            end
        end
    end

endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer: bit-level reference model feeds a byte scoreboard.
module tb_huffman_packer;
    import huffman_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_valid;
    logic       flush;
    logic       done;
    logic       err;
    logic [15:0] sym_cnt;
    logic [7:0] hc_drv [6];
    logic [7:0] m_drv  [6];

    huffman_packer_if bus ();

    huffman_packer dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1 (hc_drv[0]), .HC2 (hc_drv[1]), .HC3 (hc_drv[2]),
        .HC4 (hc_drv[3]), .HC5 (hc_drv[4]), .HC6 (hc_drv[5]),
        .M1  (m_drv[0]),  .M2  (m_drv[1]),  .M3  (m_drv[2]),
        .M4  (m_drv[3]),  .M5  (m_drv[4]),  .M6  (m_drv[5]),
        .flush      (flush),
        .stream     (bus),
        .done       (done),
        .err        (err),
        .sym_cnt    (sym_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] CT_HC [6] = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    localparam logic [7:0] CT_M  [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    localparam logic [7:0] FF_T  [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    int         n_assert = 0;
    int         n_fail   = 0;
    int         exp_cnt  = 0;
    logic       exp_err  = 1'b0;
    logic [7:0] mdl_hc  [6];
    int         mdl_len [6];
    logic       bits [$];
    logic [7:0] sb   [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.byte_valid && bus.byte_ready) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_byte observed=%02h expected=none", bus.byte_out);
            end
            if (sb.size() != 0) check("byte_out", {24'h0, bus.byte_out}, {24'h0, sb.pop_front()});
        end
    end

    task automatic model_pack();
        logic [7:0] b;
        while (bits.size() >= 8) begin
            b = '0;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits.pop_front()};
            sb.push_back(b);
        end
    endtask

    task automatic load_table(input logic [7:0] hc [6], input logic [7:0] m [6], input bit take);
        int n;
        for (int k = 0; k < 6; k++) begin
            hc_drv[k] = hc[k];
            m_drv[k]  = m[k];
            if (take) begin
                n = 0;
                for (int b = 0; b < 8; b++) n += int'(m[k][b]);
                mdl_hc[k]  = hc[k];
                mdl_len[k] = n;
            end
        end
        code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_sym(input logic [7:0] s);
        bit ok;
        int k;
        ok = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym       = s;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.sym_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.sym_valid = 1'b0;
        check("sym_accepted", {31'h0, ok}, 32'h1);
        exp_cnt++;
        k = int'(s) - 1;
        if (s >= 8'd1 && s <= 8'd6 && mdl_len[k] > 0) begin
            for (int b = mdl_len[k] - 1; b >= 0; b--) bits.push_back(mdl_hc[k][b]);
            model_pack();
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic do_flush(input string tag);
        int pulses;
        if (bits.size() > 0) begin
            while (bits.size() < 8) bits.push_back(1'b0);
            model_pack();
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        @(posedge clk); #1;
        check(tag, pulses, 1);
    endtask

    initial begin
        reset         = 1'b1;
        code_valid    = 1'b0;
        flush         = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym       = '0;
        bus.byte_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            hc_drv[k] = '0;
            m_drv[k]  = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_valid", {31'h0, bus.byte_valid}, 32'h0);
        check("rst_byte_out",   {24'h0, bus.byte_out},   32'h0);
        check("rst_sym_ready",  {31'h0, bus.sym_ready},  32'h0);
        check("rst_done",       {31'h0, done},           32'h0);
        check("rst_err",        {31'h0, err},            32'h0);
        check("rst_sym_cnt",    {16'h0, sym_cnt},        32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("idle_no_ready", {31'h0, bus.sym_ready}, 32'h0);

        // Common table, 1,2,3,4 then flush -> 5B, 80
        load_table(CT_HC, CT_M, 1'b1);
        check("run_ready", {31'h0, bus.sym_ready}, 32'h1);
        send_sym(8'd1); send_sym(8'd2); send_sym(8'd3); send_sym(8'd4);
        do_flush("done_flush_partial");
        check("cnt_after_1234", {16'h0, sym_cnt}, exp_cnt);

        // Eight sym-6 codewords -> five 0xFF bytes, bcnt ends at 0
        for (int i = 0; i < 8; i++) send_sym(8'd6);
        repeat (3) @(posedge clk); #1;
        check("bcnt_zero",     {27'h0, dut.bcnt_q},     32'h0);
        check("no_byte_idle",  {31'h0, bus.byte_valid}, 32'h0);
        check("cnt_after_66",  {16'h0, sym_cnt},        exp_cnt);

        // Backpressure: byte held stable, no symbols accepted
        bus.byte_ready = 1'b0;
        send_sym(8'd6); send_sym(8'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_byte_valid", {31'h0, bus.byte_valid}, 32'h1);
            check("bp_sym_ready",  {31'h0, bus.sym_ready},  32'h0);
            check("bp_byte_out",   {24'h0, bus.byte_out},   32'hFF);
        end
        @(posedge clk); #1;
        bus.byte_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_consumed", {31'h0, bus.byte_valid}, 32'h0);
        do_flush("done_flush_bp");

        // Invalid symbols: error, no bits, still counted
        send_sym(8'd0); send_sym(8'd9);
        repeat (3) @(posedge clk); #1;
        check("err_set",        {31'h0, err},            {31'h0, exp_err});
        check("err_no_byte",    {31'h0, bus.byte_valid}, 32'h0);
        check("cnt_after_bad",  {16'h0, sym_cnt},        exp_cnt);

        // Flush with nothing pending, then a code_valid edge in RUN is ignored
        do_flush("done_flush_empty");
        load_table(FF_T, FF_T, 1'b0);
        for (int i = 0; i < 8; i++) send_sym(8'd1);
        repeat (3) @(posedge clk); #1;
        check("cnt_after_reload", {16'h0, sym_cnt}, exp_cnt);
        check("err_sticky",       {31'h0, err},     32'h1);

        // Mid-stream reset with 5 bits pending, code_valid held high across it
        send_sym(8'd6);
        @(negedge clk);
        check("pre_rst_bcnt", {27'h0, dut.bcnt_q}, 32'd5);
        code_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        bits.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        check("mid_rst_state",      {30'h0, dut.state_q},    {30'h0, IDLE});
        check("mid_rst_byte_valid", {31'h0, bus.byte_valid}, 32'h0);
        check("mid_rst_byte_out",   {24'h0, bus.byte_out},   32'h0);
        check("mid_rst_sym_ready",  {31'h0, bus.sym_ready},  32'h0);
        check("mid_rst_err",        {31'h0, err},            32'h0);
        check("mid_rst_done",       {31'h0, done},           32'h0);
        check("mid_rst_sym_cnt",    {16'h0, sym_cnt},        32'h0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held_cv_no_ready", {31'h0, bus.sym_ready}, 32'h0);
        end
        @(posedge clk); #1;
        code_valid = 1'b0;
        @(posedge clk); #1;
        load_table(CT_HC, CT_M, 1'b1);
        check("reload_ready", {31'h0, bus.sym_ready}, 32'h1);
        send_sym(8'd2); send_sym(8'd2); send_sym(8'd4);
        repeat (3) @(posedge clk); #1;
        check("cnt_after_rst", {16'h0, sym_cnt}, exp_cnt);
        do_flush("done_flush_final");

        repeat (5) @(posedge clk); #1;
        check("sb_drained", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
